// File: rtl/tdc_pkg.sv
// Shared types and width helpers for the multichannel TDC decoder.
// Also used by tdc_popcount_serial for its fine-count width.
package tdc_pkg;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARMED     = 3'd1,
        ST_DEC_START = 3'd2,
        ST_DEC_STOP  = 3'd3,
        ST_OUTPUT    = 3'd4
    } tdc_state_e;

    function automatic int fine_w(input int chain_len);
        return $clog2(chain_len + 1);
    endfunction

    function automatic int res_w(input int coarse_w, input int chain_len);
        return coarse_w + fine_w(chain_len) + 1;
    endfunction

    // Result record at the default geometry (16 channels max, 144-cell chain)
    localparam int DEF_CH_W     = 4;
    localparam int DEF_COARSE_W = 32;
    localparam int DEF_FINE_W   = 8;
    localparam int DEF_RES_W    = 41;

    typedef struct packed {
        logic [DEF_CH_W-1:0]     ch;
        logic [DEF_COARSE_W-1:0] coarse;
        logic [DEF_FINE_W-1:0]   fine_start;
        logic [DEF_FINE_W-1:0]   fine_stop;
        logic [DEF_RES_W-1:0]    interval;
        logic                    overflow;
    } tdc_result_t;

endpackage

// File: rtl/tdc_popcount_serial.sv
// Sliced serial popcount of a thermometer snapshot, SLICE_W bits per cycle.
// Define TDC_BUBBLE_FILTER_EN to add a 3-tap majority bubble filter (+1 cycle).
module tdc_popcount_serial
    import tdc_pkg::*;
#(
    parameter int CHAIN_LEN = 144,
    parameter int SLICE_W   = 8,
    localparam int FINE_W   = fine_w(CHAIN_LEN),
    localparam int NSLICE   = (CHAIN_LEN + SLICE_W - 1) / SLICE_W,
    localparam int PAD_W    = NSLICE * SLICE_W,
    localparam int CNT_W    = $clog2(NSLICE + 1)
)(
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 load,
    input  logic [CHAIN_LEN-1:0] code,
    output logic                 done,
    output logic [FINE_W-1:0]    count
);

    logic [CHAIN_LEN-1:0] src;
    logic                 src_vld;
    logic [PAD_W-1:0]     shreg;
    logic [FINE_W-1:0]    acc;
    logic [FINE_W-1:0]    slice_pc;
    logic [CNT_W-1:0]     left;
    logic                 active;

`ifdef TDC_BUBBLE_FILTER_EN
    logic [CHAIN_LEN-1:0] raw_q;
    logic [CHAIN_LEN+1:0] ext;
    logic                 raw_vld;

    // Chain edges: a virtual 1 below bit 0 and a virtual 0 above the top bit
    assign ext = {1'b0, raw_q, 1'b1};

    always_comb begin
        src = '0;
        for (int i = 0; i < CHAIN_LEN; i++) begin
            src[i] = (ext[i] & ext[i+1]) | (ext[i] & ext[i+2])
                   | (ext[i+1] & ext[i+2]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            raw_q   <= '0;
            raw_vld <= 1'b0;
        end else begin
            raw_vld <= load;
            if (load) raw_q <= code;
        end
    end

    assign src_vld = raw_vld;
`else
    assign src     = code;
    assign src_vld = load;
`endif

    always_comb begin
        slice_pc = '0;
        for (int i = 0; i < SLICE_W; i++) begin
            slice_pc = slice_pc + FINE_W'(shreg[i]);
        end
    end

    // Final total is visible combinationally during the last slice cycle
    assign count = acc + slice_pc;
    assign done  = active && (left == '0);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            shreg  <= '0;
            acc    <= '0;
            left   <= '0;
            active <= 1'b0;
        end else if (src_vld) begin
            shreg  <= PAD_W'(src);
            acc    <= '0;
            left   <= CNT_W'(NSLICE - 1);
            active <= 1'b1;
        end else if (active) begin
            shreg <= shreg >> SLICE_W;
            acc   <= count;
            left  <= left - CNT_W'(1);
            if (left == '0) active <= 1'b0;
        end
    end

endmodule

// File: rtl/tdc_multichannel_decoder.sv
// One-start / NCH-stop TDC: coarse counting, serial fine decode, result stream.
// Optional macro TDC_BUBBLE_FILTER_EN enables the fine-code bubble filter.
module tdc_multichannel_decoder
    import tdc_pkg::*;
#(
    parameter int NCH        = 4,
    parameter int CHAIN_LEN  = 144,
    parameter int SLICE_W    = 8,
    parameter int CLK_BINS   = 144,
    parameter int COARSE_W   = 32,
    parameter int MAX_COARSE = 1000,
    localparam int FINE_W    = fine_w(CHAIN_LEN),
    localparam int RES_W     = res_w(COARSE_W, CHAIN_LEN),
    localparam int CH_W      = (NCH > 1) ? $clog2(NCH) : 1
)(
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     start_valid,
    input  logic [CHAIN_LEN-1:0]     start_code,
    input  logic [NCH-1:0]           stop_valid,
    input  logic [NCH*CHAIN_LEN-1:0] stop_code,
    input  logic [NCH-1:0]           ch_en,
    output logic                     busy,
    output logic                     res_valid,
    input  logic                     res_ready,
    output logic [CH_W-1:0]          res_ch,
    output logic [COARSE_W-1:0]      res_coarse,
    output logic [FINE_W-1:0]        res_fine_start,
    output logic [FINE_W-1:0]        res_fine_stop,
    output logic [RES_W-1:0]         res_interval,
    output logic                     res_overflow
);

    tdc_state_e           state;
    logic [CHAIN_LEN-1:0] start_code_q;
    logic [NCH-1:0]       ch_en_q;
    logic [NCH-1:0]       stop_seen;
    logic [NCH-1:0]       ovf_q;
    logic [NCH-1:0]       pending;
    logic [COARSE_W-1:0]  coarse;
    logic [CHAIN_LEN-1:0] stop_code_q [NCH];
    logic [COARSE_W-1:0]  stop_coarse [NCH];
    logic [FINE_W-1:0]    fine_start_q;
    logic [FINE_W-1:0]    fine_stop_q;
    logic [CH_W-1:0]      cur_ch;
    logic [CH_W-1:0]      sel_ch;
    logic                 calc;

    logic                 pc_load;
    logic                 pc_done;
    logic [CHAIN_LEN-1:0] pc_code;
    logic [FINE_W-1:0]    pc_count;

    logic                 start_ok;
    logic                 all_seen;
    logic                 timeout;
    logic                 arm_exit;
    logic                 enter_stop;
    logic [RES_W-1:0]     scaled;
    logic [RES_W-1:0]     diff;
    logic                 negative;

    assign busy     = (state != ST_IDLE);
    assign start_ok = start_valid && (ch_en != '0);
    assign all_seen = ((stop_seen & ch_en_q) == ch_en_q);
    assign timeout  = (coarse == COARSE_W'(MAX_COARSE));
    assign arm_exit = (state == ST_ARMED) && (all_seen || timeout);

    assign enter_stop = ((state == ST_DEC_START) && pc_done)
                     || ((state == ST_OUTPUT) && res_ready && (pending != '0));

    // Lowest-index pending channel is decoded next
    always_comb begin
        sel_ch = '0;
        for (int k = NCH - 1; k >= 0; k--) begin
            if (pending[k]) sel_ch = CH_W'(k);
        end
    end

    always_comb begin
        pc_load = 1'b0;
        pc_code = stop_code_q[sel_ch];
        if (arm_exit) begin
            pc_load = 1'b1;
            pc_code = start_code_q;
        end else if (enter_stop && !ovf_q[sel_ch]) begin
            pc_load = 1'b1;
        end
    end

    always_comb begin
        scaled = RES_W'(stop_coarse[cur_ch]) * RES_W'(CLK_BINS)
               + RES_W'(fine_stop_q);
        negative = (scaled < RES_W'(fine_start_q));
        diff     = scaled - RES_W'(fine_start_q);
    end

    tdc_popcount_serial #(
        .CHAIN_LEN (CHAIN_LEN),
        .SLICE_W   (SLICE_W)
    ) u_popcount (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (pc_load),
        .code  (pc_code),
        .done  (pc_done),
        .count (pc_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state          <= ST_IDLE;
            start_code_q   <= '0;
            ch_en_q        <= '0;
            stop_seen      <= '0;
            ovf_q          <= '0;
            pending        <= '0;
            coarse         <= '0;
            fine_start_q   <= '0;
            fine_stop_q    <= '0;
            cur_ch         <= '0;
            calc           <= 1'b0;
            res_valid      <= 1'b0;
            res_ch         <= '0;
            res_coarse     <= '0;
            res_fine_start <= '0;
            res_fine_stop  <= '0;
            res_interval   <= '0;
            res_overflow   <= 1'b0;
            for (int k = 0; k < NCH; k++) begin
                stop_code_q[k] <= '0;
                stop_coarse[k] <= '0;
            end
        end else begin
            if (enter_stop) begin
                cur_ch          <= sel_ch;
                pending[sel_ch] <= 1'b0;
                calc            <= 1'b0;
            end
            case (state)
                ST_IDLE: begin
                    if (start_ok) begin
                        start_code_q <= start_code;
                        ch_en_q      <= ch_en;
                        coarse       <= '0;
                        ovf_q        <= '0;
                        stop_seen    <= stop_valid & ch_en;
                        state        <= ST_ARMED;
                        for (int k = 0; k < NCH; k++) begin
                            stop_code_q[k] <= stop_code[k*CHAIN_LEN +: CHAIN_LEN];
                            stop_coarse[k] <= '0;
                        end
                    end
                end
                ST_ARMED: begin
                    if (all_seen || timeout) begin
                        state   <= ST_DEC_START;
                        pending <= ch_en_q;
                        for (int k = 0; k < NCH; k++) begin
                            if (!all_seen && ch_en_q[k] && !stop_seen[k]) begin
                                ovf_q[k]       <= 1'b1;
                                stop_coarse[k] <= COARSE_W'(MAX_COARSE);
                            end
                        end
                    end else begin
                        coarse <= coarse + COARSE_W'(1);
                        for (int k = 0; k < NCH; k++) begin
                            if (stop_valid[k] && ch_en_q[k] && !stop_seen[k]) begin
                                stop_seen[k]   <= 1'b1;
                                stop_code_q[k] <= stop_code[k*CHAIN_LEN +: CHAIN_LEN];
                                stop_coarse[k] <= coarse + COARSE_W'(1);
                            end
                        end
                    end
                end
                ST_DEC_START: begin
                    if (pc_done) begin
                        fine_start_q <= pc_count;
                        state        <= ST_DEC_STOP;
                    end
                end
                ST_DEC_STOP: begin
                    if (!calc) begin
                        if (ovf_q[cur_ch]) begin
                            fine_stop_q <= '0;
                            calc        <= 1'b1;
                        end else if (pc_done) begin
                            fine_stop_q <= pc_count;
                            calc        <= 1'b1;
                        end
                    end else begin
                        res_ch         <= cur_ch;
                        res_coarse     <= stop_coarse[cur_ch];
                        res_fine_start <= fine_start_q;
                        res_fine_stop  <= fine_stop_q;
                        res_interval   <= negative ? '0 : diff;
                        res_overflow   <= negative | ovf_q[cur_ch];
                        res_valid      <= 1'b1;
                        calc           <= 1'b0;
                        state          <= ST_OUTPUT;
                    end
                end
                ST_OUTPUT: begin
                    if (res_ready) begin
                        res_valid <= 1'b0;
                        state     <= (pending != '0) ? ST_DEC_STOP : ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_tdc_multichannel_decoder.sv
// Scoreboard bench for tdc_multichannel_decoder, directed vectors.
// Expected fine values track TDC_BUBBLE_FILTER_EN when it is defined.
module tb_tdc_multichannel_decoder;
    import tdc_pkg::*;

`ifdef TDC_BUBBLE_FILTER_EN
    localparam int LAT = 40;
    localparam int FS6 = 40;
`else
    localparam int LAT = 38;
    localparam int FS6 = 39;
`endif

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start_valid = 1'b0;
    logic [143:0] start_code = '0;
    logic [3:0]   stop_valid = '0;
    logic [575:0] stop_code = '0;
    logic [3:0]   ch_en = '0;
    logic         busy;
    logic         res_valid;
    logic         res_ready = 1'b1;
    logic [1:0]   res_ch;
    logic [31:0]  res_coarse;
    logic [7:0]   res_fine_start;
    logic [7:0]   res_fine_stop;
    logic [40:0]  res_interval;
    logic         res_overflow;

    int checks = 0;
    int errors = 0;
    int xfers  = 0;

    tdc_result_t exp_q[$];
    tdc_result_t snap;
    tdc_result_t mon_act;
    tdc_result_t mon_exp;
    bit          have_snap = 0;

    always #5 clk = ~clk;

    tdc_multichannel_decoder #(
        .NCH(4), .CHAIN_LEN(144), .SLICE_W(8), .CLK_BINS(144),
        .COARSE_W(32), .MAX_COARSE(1000)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .start_valid(start_valid), .start_code(start_code),
        .stop_valid(stop_valid), .stop_code(stop_code), .ch_en(ch_en),
        .busy(busy), .res_valid(res_valid), .res_ready(res_ready),
        .res_ch(res_ch), .res_coarse(res_coarse),
        .res_fine_start(res_fine_start), .res_fine_stop(res_fine_stop),
        .res_interval(res_interval), .res_overflow(res_overflow)
    );

    function automatic logic [143:0] therm(input int n);
        logic [143:0] v;
        v = '0;
        for (int i = 0; i < n; i++) v[i] = 1'b1;
        return v;
    endfunction

    function automatic logic [575:0] stops(input int n0, input int n1,
                                           input int n2, input int n3);
        return {therm(n3), therm(n2), therm(n1), therm(n0)};
    endfunction

    function automatic string fmt(input tdc_result_t r);
        return $sformatf("ch=%0d coarse=%0d fs=%0d fp=%0d int=%0d ov=%0d",
                         r.ch, r.coarse, r.fine_start, r.fine_stop,
                         r.interval, r.overflow);
    endfunction

    function automatic tdc_result_t cur_res();
        tdc_result_t r;
        r.ch         = 4'(res_ch);
        r.coarse     = res_coarse;
        r.fine_start = res_fine_start;
        r.fine_stop  = res_fine_stop;
        r.interval   = res_interval;
        r.overflow   = res_overflow;
        return r;
    endfunction

    // Monitor: pops on every transfer, checks hold stability while stalled
    always @(negedge clk) begin
        if (!rst_n) begin
            have_snap = 0;
        end else if (res_valid) begin
            mon_act = cur_res();
            if (have_snap) begin
                checks++;
                if (mon_act !== snap) begin
                    errors++;
                    $display("FAIL hold: got %s, required %s",
                             fmt(mon_act), fmt(snap));
                end
            end
            if (res_ready) begin
                xfers++;
                checks++;
                have_snap = 0;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_result: got %s, none expected",
                             fmt(mon_act));
                end else begin
                    mon_exp = exp_q.pop_front();
                    if (mon_act !== mon_exp) begin
                        errors++;
                        $display("FAIL result%0d: got %s, required %s",
                                 xfers, fmt(mon_act), fmt(mon_exp));
                    end
                end
            end else begin
                snap      = mon_act;
                have_snap = 1;
            end
        end else begin
            have_snap = 0;
        end
    end

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic check(input string name, input logic [63:0] got,
                         input logic [63:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %0d, required %0d", name, got, want);
        end
    endtask

    task automatic push(input int ch, input int co, input int fs,
                        input int fp, input longint iv, input bit ov);
        tdc_result_t r;
        r.ch         = 4'(ch);
        r.coarse     = 32'(co);
        r.fine_start = 8'(fs);
        r.fine_stop  = 8'(fp);
        r.interval   = 41'(iv);
        r.overflow   = ov;
        exp_q.push_back(r);
    endtask

    task automatic launch(input logic [3:0] en, input logic [143:0] sc,
                          input logic [3:0] smask, input logic [575:0] stc,
                          input int d);
        start_valid = 1'b1;
        start_code  = sc;
        ch_en       = en;
        stop_code   = stc;
        if (d == 0) stop_valid = smask;
        step();
        start_valid = 1'b0;
        stop_valid  = '0;
        if (d > 0) begin
            repeat (d - 1) step();
            stop_valid = smask;
            step();
            stop_valid = '0;
        end
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n;
        n = 0;
        while (busy && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (busy) begin
            errors++;
            $display("FAIL %s: still busy after %0d cycles, required idle",
                     name, n);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish, required finish");
        $fatal(1);
    end

    initial begin
        int n;
        int base;
        logic [143:0] bub;

        repeat (3) step();
        check("rst_res_valid", 64'(res_valid), 0);
        check("rst_busy", 64'(busy), 0);
        check("rst_interval", 64'(res_interval), 0);
        check("rst_coarse", 64'(res_coarse), 0);
        rst_n = 1'b1;
        step();

        // Basic measurement plus first-result latency
        launch(4'b0001, therm(20), 4'b0001, stops(100, 0, 0, 0), 10);
        push(0, 10, 20, 100, 1520, 0);
        n = 0;
        while (!res_valid && n < 100) begin
            step();
            n++;
        end
        check("t1_latency", 64'(n), 64'(LAT));
        wait_idle("t1_idle", 200);

        // Same-cycle start and stop, positive and negative fine difference
        launch(4'b0001, therm(30), 4'b0001, stops(50, 0, 0, 0), 0);
        push(0, 0, 30, 50, 20, 0);
        wait_idle("t2a_idle", 200);
        launch(4'b0001, therm(50), 4'b0001, stops(30, 0, 0, 0), 0);
        push(0, 0, 50, 30, 0, 1);
        wait_idle("t2b_idle", 200);

        start_valid = 1'b1;
        start_code  = therm(10);
        ch_en       = 4'b0000;
        step();
        start_valid = 1'b0;
        check("no_enable_ignored", 64'(busy), 0);

        // Timeout on ch1; stop on disabled ch2 is ignored
        base = xfers;
        launch(4'b0011, therm(10), 4'b0101, stops(60, 0, 90, 0), 5);
        push(0, 5, 10, 60, 770, 0);
        push(1, 1000, 10, 0, 143990, 1);
        n = 0;
        while (xfers < base + 1 && n < 1500) begin
            step();
            n++;
        end
        check("t3_first_xfer", 64'(xfers - base), 1);
        check("t3_busy_between", 64'(busy), 1);
        wait_idle("t3_idle", 200);
        check("t3_xfer_count", 64'(xfers - base), 2);

        // Back-pressure: outputs held while res_ready is low
        res_ready = 1'b0;
        base = xfers;
        launch(4'b0101, therm(25), 4'b0101, stops(40, 0, 70, 0), 7);
        push(0, 7, 25, 40, 1023, 0);
        push(2, 7, 25, 70, 1053, 0);
        n = 0;
        while (!res_valid && n < 100) begin
            step();
            n++;
        end
        check("t4_valid_seen", 64'(res_valid), 1);
        repeat (50) step();
        check("t4_no_xfer_stalled", 64'(xfers - base), 0);
        res_ready = 1'b1;
        wait_idle("t4_idle", 200);
        check("t4_xfer_count", 64'(xfers - base), 2);

        // Reset while decoding the stop code aborts the measurement
        launch(4'b0001, therm(15), 4'b0001, stops(80, 0, 0, 0), 2);
        repeat (25) step();
        check("t5_busy_before", 64'(busy), 1);
        rst_n = 1'b0;
        step();
        check("t5_res_valid", 64'(res_valid), 0);
        check("t5_busy", 64'(busy), 0);
        rst_n = 1'b1;
        step();
        launch(4'b0001, therm(5), 4'b0001, stops(9, 0, 0, 0), 3);
        push(0, 3, 5, 9, 436, 0);
        wait_idle("t5_idle", 200);

        // Bubble at bit 37 inside a 40-cell thermometer
        bub = therm(40);
        bub[37] = 1'b0;
        launch(4'b0001, bub, 4'b0001, stops(100, 0, 0, 0), 1);
        push(0, 1, FS6, 100, 144 + 100 - FS6, 0);
        wait_idle("t6_idle", 200);

        n = 0;
        while (exp_q.size() != 0 && n < 100) begin
            step();
            n++;
        end
        check("queue_empty", 64'(exp_q.size()), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
